// File: rtl/btn_debounce.sv
// Debounces a bouncing push button. The button is synchronized into the clk
// domain, then a 4-state FSM only accepts a press or release after
// DEBOUNCE_CYCLES consecutive stable samples. It also generates optional
// auto-repeat pulses while the button is held. All outputs come straight
// from flops.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter bit BTN_ACTIVE_LOW  = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic btn_pulse,
  output logic btn_level,
  output logic btn_release
);

  localparam int CNT_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = (RPT_MAX > 2) ? $clog2(RPT_MAX) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'((REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0);
  localparam bit               REPEAT_EN   = (REPEAT_DELAY > 0);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [RPT_W-1:0] rpt, rpt_nxt;
  logic             rpt_first, rpt_first_nxt;
  logic             pulse_nxt, level_nxt, release_nxt;
  logic             sync1, sync2;
  logic             pressed;

  // Two-flop synchronizer. During reset it is loaded with the released level,
  // so a button held through reset is seen as a fresh press afterwards.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1 <= BTN_ACTIVE_LOW;
      sync2 <= BTN_ACTIVE_LOW;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  assign pressed = sync2 ^ BTN_ACTIVE_LOW;

  // State, counters and output strobes register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      rpt         <= '0;
      rpt_first   <= 1'b0;
      btn_pulse   <= 1'b0;
      btn_level   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      rpt         <= rpt_nxt;
      rpt_first   <= rpt_first_nxt;
      btn_pulse   <= pulse_nxt;
      btn_level   <= level_nxt;
      btn_release <= release_nxt;
    end
  end

  // Next-state logic. The repeat counter only moves on cycles spent in HELD
  // with the button pressed, so a rejected release glitch just delays the
  // next repeat by the cycles it lasted. It never restarts the repeat interval.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    rpt_nxt       = rpt;
    rpt_first_nxt = rpt_first;
    pulse_nxt     = 1'b0;
    level_nxt     = btn_level;
    release_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (pressed) begin
          state_nxt = PRESS_CHK;
          cnt_nxt   = '0;
        end
      end
      PRESS_CHK: begin
        if (!pressed) begin
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nxt     = HELD;
          pulse_nxt     = 1'b1;
          level_nxt     = 1'b1;
          rpt_nxt       = '0;
          rpt_first_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      HELD: begin
        if (!pressed) begin
          state_nxt = REL_CHK;
          cnt_nxt   = '0;
        end else if (REPEAT_EN) begin
          if (rpt_first ? (rpt == DELAY_LAST) : (rpt == PERIOD_LAST)) begin
            pulse_nxt     = 1'b1;
            rpt_nxt       = '0;
            rpt_first_nxt = 1'b0;
          end else begin
            rpt_nxt = rpt + RPT_W'(1);
          end
        end
      end
      REL_CHK: begin
        if (pressed) begin
          state_nxt = HELD;
        end else if (cnt == CNT_LAST) begin
          state_nxt   = IDLE;
          level_nxt   = 1'b0;
          release_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
